// File: rtl/mem_arbiter.sv
// Shared-memory arbiter: grants one icache/dcache requester at a time to a single-port RAM
// and keeps dcache two-word bursts atomic. Define MEM_ARB_STATS_EN to add the arb_conflicts counter.
module mem_arbiter #(
  parameter int CPUS   = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [CPUS-1:0]          iREN,
  input  logic [CPUS*ADDR_W-1:0]   iaddr,
  output logic [CPUS-1:0]          iwait,
  output logic [DATA_W-1:0]        iload,
  input  logic [CPUS-1:0]          dREN,
  input  logic [CPUS-1:0]          dWEN,
  input  logic [CPUS-1:0]          dburst,
  input  logic [CPUS*ADDR_W-1:0]   daddr,
  input  logic [CPUS*DATA_W-1:0]   dstore,
  output logic [CPUS-1:0]          dwait,
  output logic [DATA_W-1:0]        dload,
  output logic                     ramREN,
  output logic                     ramWEN,
  output logic [ADDR_W-1:0]        ramaddr,
  output logic [DATA_W-1:0]        ramstore,
  input  logic [DATA_W-1:0]        ramload,
  input  logic [1:0]               ramstate
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [31:0]              arb_conflicts
`endif
);

  localparam int PTR_W = (CPUS > 1) ? $clog2(CPUS) : 1;
  localparam int IDX_W = $clog2(2 * CPUS);
  localparam logic [1:0] RAM_ACCESS = 2'd2;

  typedef enum logic [1:0] {IDLE, GRANT, LOCK} state_t;

  state_t             state;
  logic [IDX_W-1:0]   owner;
  logic [PTR_W-1:0]   rr_d;
  logic [PTR_W-1:0]   rr_i;

  logic [CPUS-1:0]    d_act;
  logic               any_d;
  logic               any_i;
  logic [IDX_W-1:0]   win;
  logic               own_is_d;
  logic [PTR_W-1:0]   own_n;
  logic               own_active;
  logic               done;

  // Owner indices 0..CPUS-1 are dcaches, CPUS..2*CPUS-1 are icaches.
  function automatic logic [PTR_W-1:0] rr_pick(input logic [CPUS-1:0] req,
                                               input logic [PTR_W-1:0] ptr);
    int idx;
    rr_pick = '0;
    for (int k = CPUS; k >= 1; k--) begin
      idx = int'(ptr) + k;
      if (idx >= CPUS) idx -= CPUS;
      if (req[idx]) rr_pick = PTR_W'(idx);
    end
  endfunction

  assign d_act = dREN | dWEN;
  assign any_d = |d_act;
  assign any_i = |iREN;
  assign iload = ramload;
  assign dload = ramload;

  always_comb begin
    win = '0;
    if (any_d) win = IDX_W'(rr_pick(d_act, rr_d));
    else       win = IDX_W'(CPUS) + IDX_W'(rr_pick(iREN, rr_i));
  end

  always_comb begin
    own_is_d   = (owner < IDX_W'(CPUS));
    own_n      = own_is_d ? PTR_W'(owner) : PTR_W'(owner - IDX_W'(CPUS));
    own_active = own_is_d ? d_act[own_n] : iREN[own_n];
    done       = (state == GRANT) && (ramstate == RAM_ACCESS);
  end

  // RAM is driven only while granted, so an async reset drops the enables at once.
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    if (state == GRANT) begin
      if (own_is_d) begin
        ramWEN   = dWEN[own_n];
        ramREN   = dREN[own_n] & ~dWEN[own_n];
        ramaddr  = daddr[int'(own_n)*ADDR_W +: ADDR_W];
        ramstore = dstore[int'(own_n)*DATA_W +: DATA_W];
      end else begin
        ramREN   = iREN[own_n];
        ramaddr  = iaddr[int'(own_n)*ADDR_W +: ADDR_W];
      end
    end
  end

  always_comb begin
    iwait = '1;
    dwait = '1;
    if (done) begin
      if (own_is_d) dwait[own_n] = 1'b0;
      else          iwait[own_n] = 1'b0;
    end
  end

  // A dropped request aborts without moving the class pointer.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      owner <= '0;
      rr_d  <= PTR_W'(CPUS - 1);
      rr_i  <= PTR_W'(CPUS - 1);
    end else begin
      case (state)
        IDLE: begin
          if (any_d || any_i) begin
            owner <= win;
            state <= GRANT;
          end
        end
        GRANT: begin
          if (!own_active) begin
            state <= IDLE;
          end else if (ramstate == RAM_ACCESS) begin
            if (own_is_d) rr_d <= own_n;
            else          rr_i <= own_n;
            state <= (own_is_d && dburst[own_n]) ? LOCK : IDLE;
          end
        end
        LOCK: begin
          state <= own_active ? GRANT : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MEM_ARB_STATS_EN
  logic multi_req;
  assign multi_req = ($countones({d_act, iREN}) >= 2);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      arb_conflicts <= '0;
    else if ((state == IDLE) && multi_req && (arb_conflicts != 32'hFFFF_FFFF))
      arb_conflicts <= arb_conflicts + 32'd1;
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a hand-driven 1-cycle RAM.
module tb_mem_arbiter;

  localparam int CPUS = 2;
  localparam logic [1:0] FREE   = 2'd0;
  localparam logic [1:0] BUSY   = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;

  logic        CLK;
  logic        RST;
  logic [1:0]  iREN;
  logic [63:0] iaddr;
  logic [1:0]  iwait;
  logic [31:0] iload;
  logic [1:0]  dREN;
  logic [1:0]  dWEN;
  logic [1:0]  dburst;
  logic [63:0] daddr;
  logic [63:0] dstore;
  logic [1:0]  dwait;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;
`ifdef MEM_ARB_STATS_EN
  logic [31:0] arbConflicts;
`endif

  int compared;
  int mismatched;

  mem_arbiter #(.CPUS(CPUS), .ADDR_W(32), .DATA_W(32)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .dburst(dburst), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
`ifdef MEM_ARB_STATS_EN
    , .arb_conflicts(arbConflicts)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One cycle: inputs change 1 time unit after the rising edge.
  task automatic applyStimulus(input logic [1:0] dren, input logic [1:0] dwen,
                               input logic [1:0] dbst, input logic [1:0] iren,
                               input logic [1:0] rs, input logic [31:0] load);
    @(posedge CLK);
    #1;
    dREN = dren;
    dWEN = dwen;
    dburst = dbst;
    iREN = iren;
    ramstate = rs;
    ramload = load;
  endtask

  task automatic clearInputs();
    iREN = '0; iaddr = '0; dREN = '0; dWEN = '0; dburst = '0;
    daddr = '0; dstore = '0; ramload = '0; ramstate = FREE;
  endtask

  task automatic doReset();
    RST = 1'b1;
    clearInputs();
    @(posedge CLK);
    @(posedge CLK);
    #1;
    RST = 1'b0;
  endtask

  initial begin
    compared = 0;
    mismatched = 0;
    RST = 1'b1;
    clearInputs();
    #2;
    checkOutput("rst_ramREN", 64'(ramREN), 64'd0);
    checkOutput("rst_ramWEN", 64'(ramWEN), 64'd0);
    checkOutput("rst_ramaddr", 64'(ramaddr), 64'd0);
    checkOutput("rst_ramstore", 64'(ramstore), 64'd0);
    checkOutput("rst_iwait", 64'(iwait), 64'h3);
    checkOutput("rst_dwait", 64'(dwait), 64'h3);
    doReset();

    $display("[TB] single icache read");
    applyStimulus(2'b00, 2'b00, 2'b00, 2'b01, FREE, 32'h0);
    iaddr[31:0] = 32'h100;
    #2;
    checkOutput("t1_idle_ren", 64'(ramREN), 64'd0);
    checkOutput("t1_idle_iwait", 64'(iwait), 64'h3);
    applyStimulus(2'b00, 2'b00, 2'b00, 2'b01, ACCESS, 32'hDEADBEEF);
    #2;
    checkOutput("t1_ren", 64'(ramREN), 64'd1);
    checkOutput("t1_addr", 64'(ramaddr), 64'h100);
    checkOutput("t1_iwait", 64'(iwait), 64'h2);
    checkOutput("t1_iload", 64'(iload), 64'hDEADBEEF);
    checkOutput("t1_dload", 64'(dload), 64'hDEADBEEF);
    applyStimulus(2'b00, 2'b00, 2'b00, 2'b00, FREE, 32'h0);
    #2;
    checkOutput("t1_back_idle", 64'(ramREN), 64'd0);
    checkOutput("t1_back_iwait", 64'(iwait), 64'h3);

    $display("[TB] dcache beats icache");
    doReset();
    applyStimulus(2'b01, 2'b00, 2'b00, 2'b01, FREE, 32'h0);
    iaddr[31:0] = 32'h400;
    daddr[31:0] = 32'h200;
    #2;
    checkOutput("t2_idle_ren", 64'(ramREN), 64'd0);
    applyStimulus(2'b01, 2'b00, 2'b00, 2'b01, ACCESS, 32'h11112222);
    #2;
    checkOutput("t2_d0_addr", 64'(ramaddr), 64'h200);
    checkOutput("t2_d0_dwait", 64'(dwait), 64'h2);
    checkOutput("t2_d0_iwait", 64'(iwait), 64'h3);
    checkOutput("t2_d0_dload", 64'(dload), 64'h11112222);
    applyStimulus(2'b00, 2'b00, 2'b00, 2'b01, FREE, 32'h0);
    #2;
    checkOutput("t2_gap_ren", 64'(ramREN), 64'd0);
    checkOutput("t2_gap_iwait", 64'(iwait), 64'h3);
    applyStimulus(2'b00, 2'b00, 2'b00, 2'b01, ACCESS, 32'h33334444);
    #2;
    checkOutput("t2_i0_ren", 64'(ramREN), 64'd1);
    checkOutput("t2_i0_addr", 64'(ramaddr), 64'h400);
    checkOutput("t2_i0_iwait", 64'(iwait), 64'h2);
    checkOutput("t2_i0_dwait", 64'(dwait), 64'h3);

    $display("[TB] dcache writeback burst with competing d1");
    doReset();
    applyStimulus(2'b10, 2'b01, 2'b01, 2'b00, FREE, 32'h0);
    daddr[31:0] = 32'h300;
    dstore[31:0] = 32'hAAAA0001;
    daddr[63:32] = 32'h500;
    #2;
    checkOutput("t3_idle_wen", 64'(ramWEN), 64'd0);
    applyStimulus(2'b10, 2'b01, 2'b01, 2'b00, ACCESS, 32'h0);
    #2;
    checkOutput("t3_w0_wen", 64'(ramWEN), 64'd1);
    checkOutput("t3_w0_ren", 64'(ramREN), 64'd0);
    checkOutput("t3_w0_addr", 64'(ramaddr), 64'h300);
    checkOutput("t3_w0_store", 64'(ramstore), 64'hAAAA0001);
    checkOutput("t3_w0_dwait", 64'(dwait), 64'h2);
    applyStimulus(2'b10, 2'b01, 2'b00, 2'b00, FREE, 32'h0);
    daddr[31:0] = 32'h304;
    dstore[31:0] = 32'hAAAA0002;
    #2;
    checkOutput("t3_lock_wen", 64'(ramWEN), 64'd0);
    checkOutput("t3_lock_ren", 64'(ramREN), 64'd0);
    checkOutput("t3_lock_dwait", 64'(dwait), 64'h3);
    applyStimulus(2'b10, 2'b01, 2'b00, 2'b00, ACCESS, 32'h0);
    #2;
    checkOutput("t3_w1_wen", 64'(ramWEN), 64'd1);
    checkOutput("t3_w1_addr", 64'(ramaddr), 64'h304);
    checkOutput("t3_w1_store", 64'(ramstore), 64'hAAAA0002);
    checkOutput("t3_w1_dwait", 64'(dwait), 64'h2);
    applyStimulus(2'b10, 2'b00, 2'b00, 2'b00, FREE, 32'h0);
    #2;
    checkOutput("t3_gap_ren", 64'(ramREN), 64'd0);
    applyStimulus(2'b10, 2'b00, 2'b00, 2'b00, ACCESS, 32'h0);
    #2;
    checkOutput("t3_d1_ren", 64'(ramREN), 64'd1);
    checkOutput("t3_d1_addr", 64'(ramaddr), 64'h500);
    checkOutput("t3_d1_dwait", 64'(dwait), 64'h1);

    $display("[TB] round-robin between d0 and d1");
    doReset();
    for (int k = 0; k < 4; k++) begin
      applyStimulus(2'b11, 2'b00, 2'b00, 2'b00, FREE, 32'h0);
      daddr[31:0] = 32'h600;
      daddr[63:32] = 32'h700;
      #2;
      checkOutput($sformatf("t4_idle%0d_ren", k), 64'(ramREN), 64'd0);
      applyStimulus(2'b11, 2'b00, 2'b00, 2'b00, ACCESS, 32'h0);
      #2;
      checkOutput($sformatf("t4_acc%0d_addr", k), 64'(ramaddr),
                  (k % 2 == 0) ? 64'h600 : 64'h700);
      checkOutput($sformatf("t4_acc%0d_dwait", k), 64'(dwait),
                  (k % 2 == 0) ? 64'h2 : 64'h1);
    end
    applyStimulus(2'b00, 2'b00, 2'b00, 2'b00, FREE, 32'h0);
    #2;
`ifdef MEM_ARB_STATS_EN
    checkOutput("t4_conflicts", 64'(arbConflicts), 64'd4);
`endif
    checkOutput("t4_end_ren", 64'(ramREN), 64'd0);

    $display("[TB] abort on dropped request");
    doReset();
    applyStimulus(2'b01, 2'b00, 2'b00, 2'b00, FREE, 32'h0);
    daddr[31:0] = 32'h800;
    #2;
    checkOutput("t5_idle_ren", 64'(ramREN), 64'd0);
    applyStimulus(2'b01, 2'b00, 2'b00, 2'b00, BUSY, 32'h0);
    #2;
    checkOutput("t5_busy_ren", 64'(ramREN), 64'd1);
    checkOutput("t5_busy_dwait", 64'(dwait), 64'h3);
    applyStimulus(2'b00, 2'b00, 2'b00, 2'b00, BUSY, 32'h0);
    #2;
    checkOutput("t5_drop_ren", 64'(ramREN), 64'd0);
    checkOutput("t5_drop_dwait", 64'(dwait), 64'h3);
    applyStimulus(2'b11, 2'b00, 2'b00, 2'b00, FREE, 32'h0);
    daddr[31:0] = 32'h810;
    daddr[63:32] = 32'h900;
    #2;
    checkOutput("t5_idle_after_abort", 64'(ramREN), 64'd0);
    applyStimulus(2'b11, 2'b00, 2'b00, 2'b00, ACCESS, 32'h0);
    #2;
    checkOutput("t5_rr_unchanged_addr", 64'(ramaddr), 64'h810);
    checkOutput("t5_rr_unchanged_dwait", 64'(dwait), 64'h2);

    $display("[TB] reset during busy grant");
    doReset();
    applyStimulus(2'b10, 2'b10, 2'b00, 2'b00, FREE, 32'h0);
    daddr[63:32] = 32'hA00;
    dstore[63:32] = 32'h5555;
    #2;
    checkOutput("t6_idle_wen", 64'(ramWEN), 64'd0);
    applyStimulus(2'b10, 2'b10, 2'b00, 2'b00, BUSY, 32'h0);
    #2;
    checkOutput("t6_busy_wen", 64'(ramWEN), 64'd1);
    checkOutput("t6_busy_ren", 64'(ramREN), 64'd0);
    checkOutput("t6_busy_store", 64'(ramstore), 64'h5555);
    RST = 1'b1;
    #1;
    checkOutput("t6_rst_wen", 64'(ramWEN), 64'd0);
    checkOutput("t6_rst_ren", 64'(ramREN), 64'd0);
    clearInputs();
    @(posedge CLK);
    #1;
    RST = 1'b0;
    #2;
    checkOutput("t6_post_dwait", 64'(dwait), 64'h3);
    checkOutput("t6_post_iwait", 64'(iwait), 64'h3);
    checkOutput("t6_post_addr", 64'(ramaddr), 64'h0);
    applyStimulus(2'b00, 2'b00, 2'b00, 2'b00, ACCESS, 32'h0);
    #2;
    checkOutput("t6_stay_idle_wen", 64'(ramWEN), 64'd0);
    checkOutput("t6_stay_idle_dwait", 64'(dwait), 64'h3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shared-memory arbiter and sequencer between the per-core instruction and data caches of the multicore and the single-port RAM. It grants one cache request at a time and forwards the winner's address, data and enables to RAM. It returns the per-requester wait and load signals, and keeps two-word block transfers atomic: a dcache writeback or fill is never interleaved with another requester's access.

## Interface
Parameters:
- CPUS, 2, number of cores; each core has one icache and one dcache requester
- ADDR_W, 32, address width
- DATA_W, 32, data width

Ports:
- CLK  in  1  system clock, all state on rising edge
- RST  in  1  asynchronous, active-high reset
- iREN  in  CPUS  icache read request per core
- iaddr  in  CPUS*ADDR_W  icache address; core n at bits [n*ADDR_W +: ADDR_W]
- iwait  out  CPUS  icache stall; 0 only in the completing cycle
- iload  out  DATA_W  instruction data, broadcast to all cores
- dREN, dWEN  in  CPUS each  dcache read / write request
- dburst  in  CPUS  dcache asserts while mid block (first word of WB or fill pair)
- daddr  in  CPUS*ADDR_W  dcache address
- dstore  in  CPUS*DATA_W  dcache write data
- dwait  out  CPUS  dcache stall; 0 only in the completing cycle
- dload  out  DATA_W  data read, broadcast
- ramREN, ramWEN  out  1  RAM enables
- ramaddr  out  ADDR_W  RAM address
- ramstore  out  DATA_W  RAM write data
- ramload  in  DATA_W  RAM read data
- ramstate  in  2  FREE=0, BUSY=1, ACCESS=2, ERROR=3

## Operation
- Requester set, 2*CPUS entries: d0..d(CPUS-1), i0..i(CPUS-1). A dcache is active when dREN|dWEN; dWEN beats dREN, so ramWEN=1 and ramREN=0 when both are set.
- Priority: any active dcache beats any active icache.
- Round-robin within each class: pointers rr_d and rr_i. The search starts at pointer+1. A class pointer moves to the winner's index when that winner's access completes.
- FSM states: IDLE, GRANT, LOCK. Registers: owner (index), state.
- IDLE: no RAM enables. If any requester is active, latch the winner into owner and go to GRANT. Otherwise stay in IDLE.
- GRANT: drive RAM from owner's signals.
  - ramstate==ACCESS completes the access. If owner is a dcache with dburst=1 in that cycle, go to LOCK. Otherwise go to IDLE.
  - If owner's request drops before ACCESS, abort to IDLE on the next edge. The pointer does not move.
  - BUSY and ERROR hold the state.
- LOCK: owner keeps the grant with no arbitration.
  - When owner re-asserts a request, go to GRANT the next cycle with the same owner.
  - LOCK lasts at most one idle cycle. If there is no request in LOCK, go to IDLE.
- Waits: xwait[n]=0 iff state==GRANT, owner==n, ramstate==ACCESS. Every other requester always sees wait=1.
- iload=dload=ramload, combinational, unconditional.

## Timing
- Reset values: state=IDLE, owner=0, rr_d=rr_i=CPUS-1, ramREN=ramWEN=0, ramaddr=ramstore=0, iwait=dwait=all ones.
- Arbitration latency: request first seen in IDLE at cycle t. RAM enables are driven from t+1 and are registered through owner.
- Completion: wait low in the same cycle that ramstate==ACCESS. For fixed 1-cycle RAM access, minimum request-to-data is 2 cycles.
- Back-to-back: after completion, IDLE costs one cycle before the next grant. A dburst pair costs 0 extra arbitration cycles between words.
- Simultaneous dcache requests with identical addresses are not merged; each requester gets its own access.
- RST asserted mid-access: enables drop immediately (asynchronously) and any in-flight transfer is discarded. The cache must restart its request after reset.

## Configuration
- MEM_ARB_STATS_EN defined: adds output arb_conflicts (32 bits, reset 0). It increments in every IDLE cycle where two or more requesters are active, and saturates at 0xFFFFFFFF.
- Not defined: the port and the counter are absent, and behaviour is otherwise identical.

## Test plan
- Single icache i0 reads 0x100 with 1-cycle RAM returning 0xDEADBEEF: ramREN=1 at t+1, iwait[0]=0 and iload=0xDEADBEEF at t+1, then back to IDLE.
- i0 and d0 request in the same cycle (d0 read of 0x200): d0 is granted first and i0 stays stalled until d0 completes, then i0 completes.
- d0 writeback pair at 0x300/0x304 with dburst=1 on the first word while d1 requests: both words go to RAM in sequence, then d1.
- d0 and d1 request continuously for 4 accesses: grants alternate d0,d1,d0,d1. With MEM_ARB_STATS_EN, arb_conflicts==4.
- d0 drops dREN while ramstate=BUSY: returns to IDLE the next cycle and rr_d is unchanged.
- RST pulsed during GRANT with ramstate=BUSY: ramREN/ramWEN=0 immediately, and all waits=1 after release.
